// File: rtl/gray_pkg.sv
// Shared types and Gray/binary helpers for the Gray position decoder and its reference models.
// Helpers work on a fixed wide vector; callers zero-extend narrower words.
package gray_pkg;

    localparam int GP_MAXW = 64;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        SEED = 2'd1,
        RUN  = 2'd2
    } state_e;

    // Zero upper bits decode to zero, so one wide loop serves every WIDTH.
    function automatic logic [GP_MAXW-1:0] gray2bin(input logic [GP_MAXW-1:0] g);
        logic [GP_MAXW-1:0] b;
        b = '0;
        b[GP_MAXW-1] = g[GP_MAXW-1];
        for (int i = GP_MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [GP_MAXW-1:0] bin2gray(input logic [GP_MAXW-1:0] b);
        return b ^ {1'b0, b[GP_MAXW-1:1]};
    endfunction

    function automatic int unsigned popcount_diff(input logic [GP_MAXW-1:0] a,
                                                  input logic [GP_MAXW-1:0] b);
        logic [GP_MAXW-1:0] x;
        int unsigned        n;
        x = a ^ b;
        n = 32'd0;
        for (int i = 0; i < GP_MAXW; i++) begin
            n = n + {31'd0, x[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_sync_chain.sv
// Multi-flop synchronizer for the asynchronous Gray word; kept as its own module
// so clock-domain-crossing constraints can find it by name.
module gray_sync_chain #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    import gray_pkg::*;

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] stage_d [SYNC_STAGES];

    // Shift the chain by one stage per clock.
    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Synchronizer flops, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_position_decoder.sv
// Synchronizes an asynchronous Gray position, decodes it to binary and reports
// each accepted change with a valid pulse, a direction flag and a sticky step error.
module gray_position_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             dir,
    output logic             step_err
);
    import gray_pkg::*;

    localparam int CW = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;

    logic [WIDTH-1:0]   g_s;
    logic [GP_MAXW-1:0] g_s_ext;
    logic [GP_MAXW-1:0] g_prev_ext;
    logic [GP_MAXW-1:0] bin_s_ext;
    logic [GP_MAXW-1:0] bin_prev_ext;
    logic [WIDTH-1:0]   bin_s;
    logic [WIDTH-1:0]   bin_prev;
    logic [WIDTH-1:0]   bin_prev_inc;
    int unsigned        hd_s;
    logic               unused_s;

    state_e           state_q,     state_d;
    logic [CW-1:0]    fill_cnt_q,  fill_cnt_d;
    logic [WIDTH-1:0] g_prev_q,    g_prev_d;
    logic [WIDTH-1:0] bin_out_q,   bin_out_d;
    logic             bin_valid_q, bin_valid_d;
    logic             dir_q,       dir_d;
    logic             step_err_q,  step_err_d;

    gray_sync_chain #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (gray_in),
        .q  (g_s)
    );

    // Decode current and previous Gray words and measure their Hamming distance.
    always_comb begin
        g_s_ext                  = '0;
        g_s_ext[WIDTH-1:0]       = g_s;
        g_prev_ext               = '0;
        g_prev_ext[WIDTH-1:0]    = g_prev_q;
        bin_s_ext                = gray2bin(g_s_ext);
        bin_prev_ext             = gray2bin(g_prev_ext);
        bin_s                    = bin_s_ext[WIDTH-1:0];
        bin_prev                 = bin_prev_ext[WIDTH-1:0];
        bin_prev_inc             = bin_prev + WIDTH'(1'b1);
        hd_s                     = popcount_diff(g_s_ext, g_prev_ext);
    end

    assign unused_s = ^{bin_s_ext[GP_MAXW-1:WIDTH], bin_prev_ext[GP_MAXW-1:WIDTH]};

    // Next-state and output computation; clear loses to a same-cycle error.
    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        g_prev_d    = g_prev_q;
        bin_out_d   = bin_out_q;
        bin_valid_d = 1'b0;
        dir_d       = dir_q;
        if (err_clr) begin
            step_err_d = 1'b0;
        end else begin
            step_err_d = step_err_q;
        end

        case (state_q)
            FILL: begin
                if (fill_cnt_q == CW'(SYNC_STAGES - 1)) begin
                    state_d    = SEED;
                    fill_cnt_d = '0;
                end else begin
                    fill_cnt_d = fill_cnt_q + CW'(1'b1);
                end
            end
            SEED: begin
                g_prev_d    = g_s;
                bin_out_d   = bin_s;
                bin_valid_d = 1'b1;
                state_d     = RUN;
            end
            RUN: begin
                if (hd_s == 32'd1) begin
                    g_prev_d    = g_s;
                    bin_out_d   = bin_s;
                    bin_valid_d = 1'b1;
                    dir_d       = (bin_s == bin_prev_inc);
                end else if (hd_s > 32'd1) begin
                    g_prev_d    = g_s;
                    bin_out_d   = bin_s;
                    bin_valid_d = 1'b1;
                    step_err_d  = 1'b1;
                end else begin
                    bin_valid_d = 1'b0;
                end
            end
            default: begin
                state_d    = FILL;
                fill_cnt_d = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            fill_cnt_q  <= '0;
            g_prev_q    <= '0;
            bin_out_q   <= '0;
            bin_valid_q <= 1'b0;
            dir_q       <= 1'b1;
            step_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            g_prev_q    <= g_prev_d;
            bin_out_q   <= bin_out_d;
            bin_valid_q <= bin_valid_d;
            dir_q       <= dir_d;
            step_err_q  <= step_err_d;
        end
    end

    assign bin_out   = bin_out_q;
    assign bin_valid = bin_valid_q;
    assign dir       = dir_q;
    assign step_err  = step_err_q;

endmodule

// File: tb/tb_gray_position_decoder.sv
// Self-checking bench: directed Gray sequences checked against literal expectations
// and against a cycle-level behavioural model compared on every falling edge.
module tb_gray_position_decoder;

    localparam int W  = 4;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] gray_in = 4'b0110;
    logic         err_clr = 1'b0;
    logic [W-1:0] bin_out;
    logic         bin_valid;
    logic         dir;
    logic         step_err;

    int n_cmp = 0;
    int n_bad = 0;

    gray_position_decoder #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .rst      (rst),
        .gray_in  (gray_in),
        .err_clr  (err_clr),
        .bin_out  (bin_out),
        .bin_valid(bin_valid),
        .dir      (dir),
        .step_err (step_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model decode: find the binary value whose Gray code matches, by search.
    function automatic logic [W-1:0] m_g2b(input logic [W-1:0] g);
        for (int b = 0; b < 2**W; b++) begin
            if (W'(b ^ (b >> 1)) == g) return W'(b);
        end
        return '0;
    endfunction

    function automatic int m_ones(input logic [W-1:0] x);
        int n = 0;
        for (int i = 0; i < W; i++) if (x[i]) n++;
        return n;
    endfunction

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_hist [SS];
    int           m_n;
    logic [W-1:0] m_prev, m_bin;
    logic         m_valid, m_dir, m_err;

    always @(posedge clk or posedge rst) begin
        logic [W-1:0] gs;
        if (rst) begin
            for (int k = 0; k < SS; k++) m_hist[k] = '0;
            m_n = 0; m_prev = '0; m_bin = '0; m_valid = 1'b0; m_dir = 1'b1; m_err = 1'b0;
        end else begin
            gs = m_hist[SS-1];
            for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = gray_in;
            m_valid = 1'b0;
            if (err_clr) m_err = 1'b0;
            if (m_n == SS) begin
                m_prev = gs; m_bin = m_g2b(gs); m_valid = 1'b1;
            end else if (m_n > SS) begin
                if (m_ones(gs ^ m_prev) == 1) begin
                    m_dir   = (int'(m_g2b(gs)) == (int'(m_g2b(m_prev)) + 1) % (2**W));
                    m_prev  = gs; m_bin = m_g2b(gs); m_valid = 1'b1;
                end else if (m_ones(gs ^ m_prev) > 1) begin
                    m_prev  = gs; m_bin = m_g2b(gs); m_valid = 1'b1; m_err = 1'b1;
                end
            end
            if (m_n <= SS) m_n++;
        end
    end

    // Every-cycle comparison of DUT against the model.
    always @(negedge clk) begin
        check("model_bin_out", bin_out, m_bin);
        check("model_bin_valid", bin_valid, m_valid);
        check("model_dir", dir, m_dir);
        check("model_step_err", step_err, m_err);
    end

    // Wait for the next pulse, then check its latency, payload and one-cycle width.
    task automatic wait_pulse(input string name, input logic [W-1:0] eb, input logic ed,
                              input logic ee, input int exp_lat);
        int k = 0;
        while (bin_valid !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check({name, "_latency"}, k, exp_lat);
        check({name, "_bin"}, bin_out, eb);
        check({name, "_dir"}, dir, ed);
        check({name, "_err"}, step_err, ee);
        @(negedge clk);
        check({name, "_pulse_width"}, bin_valid, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic step_to(input string name, input logic [W-1:0] g, input logic [W-1:0] eb,
                           input logic ed, input logic ee);
        @(negedge clk);
        gray_in = g;
        wait_pulse(name, eb, ed, ee, SS + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        logic [W-1:0] gb;

        check("pin_g2b_0110", m_g2b(4'b0110), 4'd4);
        check("pin_g2b_1000", m_g2b(4'b1000), 4'd15);
        check("pin_g2b_0010", m_g2b(4'b0010), 4'd3);

        repeat (3) @(negedge clk);
        check("reset_bin_out", bin_out, 4'd0);
        check("reset_dir", dir, 1'b1);
        rst = 1'b0;
        wait_pulse("seed", 4'd4, 1'b1, 1'b0, SS + 1);
        p = 0;
        repeat (5) begin
            @(negedge clk);
            if (bin_valid) p++;
        end
        check("seed_hold_quiet", p, 0);

        step_to("down3", 4'b0010, 4'd3, 1'b0, 1'b0);
        step_to("down2", 4'b0011, 4'd2, 1'b0, 1'b0);
        step_to("down1", 4'b0001, 4'd1, 1'b0, 1'b0);
        step_to("down0", 4'b0000, 4'd0, 1'b0, 1'b0);
        step_to("up1",   4'b0001, 4'd1, 1'b1, 1'b0);
        step_to("up2",   4'b0011, 4'd2, 1'b1, 1'b0);
        step_to("up3",   4'b0010, 4'd3, 1'b1, 1'b0);
        step_to("back2", 4'b0011, 4'd2, 1'b0, 1'b0);
        step_to("back1", 4'b0001, 4'd1, 1'b0, 1'b0);
        step_to("back0", 4'b0000, 4'd0, 1'b0, 1'b0);
        step_to("wrap_down", 4'b1000, 4'd15, 1'b0, 1'b0);
        step_to("wrap_up",   4'b0000, 4'd0, 1'b1, 1'b0);

        step_to("pre_err",   4'b0001, 4'd1, 1'b1, 1'b0);
        step_to("multi_bit", 4'b0010, 4'd3, 1'b1, 1'b1);
        step_to("after_err", 4'b0110, 4'd4, 1'b1, 1'b1);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check("err_clr_clears", step_err, 1'b0);
        check("err_clr_no_pulse", bin_valid, 1'b0);
        check("err_clr_bin_hold", bin_out, 4'd4);

        // err_clr lands on the same edge that detects a two-bit jump 4 -> 0.
        @(negedge clk); gray_in = 4'b0000;
        @(negedge clk);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check("collide_valid", bin_valid, 1'b1);
        check("collide_err", step_err, 1'b1);
        check("collide_bin", bin_out, 4'd0);
        repeat (2) @(negedge clk);

        for (int b = 1; b <= 8; b++) begin
            gb = W'(b ^ (b >> 1));
            step_to("climb", gb, W'(b), 1'b1, 1'b1);
        end
        step_to("to7", 4'b0100, 4'd7, 1'b0, 1'b1);

        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_bin_out", bin_out, 4'd0);
        check("midrst_valid", bin_valid, 1'b0);
        check("midrst_dir", dir, 1'b1);
        check("midrst_err", step_err, 1'b0);
        gray_in = 4'b1100;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_pulse("reseed", 4'd8, 1'b1, 1'b0, SS + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gray_position_decoder.md
Name: gray_position_decoder

Overview:
- Gray-to-binary counterpart of the binary-to-Gray encoder.
- Receives a Gray-coded position word from an asynchronous source, such as an absolute encoder or a Gray counter in a foreign domain, and synchronizes it into clk.
- Decodes the word to binary and reports each new position with a valid pulse, a direction flag and a sticky step-error flag.
- Sits between the Gray source and any binary consumer, such as a position register or a comparator.

Parameters:
- WIDTH, 4, bit width of the Gray input and binary output (minimum 2).
- SYNC_STAGES, 2, number of synchronizer flops on gray_in (minimum 2).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- gray_in  input  WIDTH  Gray-coded position, asynchronous to clk.
- err_clr  input  1  synchronous clear of step_err.
- bin_out  output  WIDTH  last accepted position, in binary.
- bin_valid  output  1  one-cycle pulse when bin_out is updated.
- dir  output  1  direction of the last accepted single-bit step (1 = up, 0 = down).
- step_err  output  1  sticky flag: a change of more than one bit was seen.

Behaviour:
- Reset (asynchronous, active-high, one clock, clk): all synchronizer flops = 0, g_prev = 0, bin_out = 0, bin_valid = 0, dir = 1, step_err = 0, state = FILL, fill counter = 0.
- Synchronizer: a SYNC_STAGES-deep flop chain on gray_in. Call its final stage g_s.
- Decode is combinational and applies to both g_s and g_prev:
  - b[WIDTH-1] = g[WIDTH-1]
  - b[i] = b[i+1] ^ g[i], for i from WIDTH-2 down to 0.
- State machine:
  - FILL: count SYNC_STAGES cycles, then go to SEED. Outputs hold their reset values.
  - SEED (one cycle): g_prev <= g_s; bin_out <= decode(g_s); bin_valid = 1. There is no step check and dir is unchanged. Next state is RUN.
  - RUN: compare g_s with g_prev every cycle.
    - g_s == g_prev: no update; bin_valid = 0.
    - Exactly one bit differs: g_prev <= g_s; bin_out <= decode(g_s); bin_valid = 1. dir = 1 if decode(g_s) == decode(g_prev)+1 modulo 2^WIDTH, else dir = 0.
    - More than one bit differs: g_prev <= g_s (resynchronize); bin_out <= decode(g_s); bin_valid = 1; step_err <= 1; dir holds.
- Latency: a gray_in change that is stable for at least SYNC_STAGES+1 cycles produces bin_valid exactly SYNC_STAGES+1 rising edges after the first sampling edge. For SYNC_STAGES=2 this is 3 cycles.
- Wrap-around:
  - gray(2^WIDTH-1) -> gray(0) is a single-bit step with dir = 1.
  - gray(0) -> gray(2^WIDTH-1) is a single-bit step with dir = 0.
  - The binary comparison is modulo 2^WIDTH.
- err_clr:
  - Clears step_err on the next edge.
  - If err_clr and a new multi-bit step occur in the same cycle, set wins and step_err = 1.
  - err_clr has no effect on any other output.
- bin_valid never stays high for two consecutive cycles, because g_prev updates in the same cycle as the pulse.
- Reset mid-operation: all outputs take their reset values immediately (asynchronously), and the state returns to FILL. After rst deasserts, the sequence FILL -> SEED repeats before RUN.
- Outputs are registered, with no combinational path from gray_in to any output.

Decomposition:
- Shared package gray_pkg:
  - state enum {FILL, SEED, RUN}.
  - Function gray2bin(WIDTH-generic loop), shared with bench reference models.
  - Function bin2gray for the bench.
  - Function popcount_diff for the Hamming-distance check.
- Sub-module gray_sync_chain (parameters WIDTH and SYNC_STAGES; ports clk, rst, d, q) holds the synchronizer flops. It is kept separate so CDC constraints can target it by name.

Test Plan (WIDTH=4, SYNC_STAGES=2):
- Reset and seed: hold gray_in=0110 through reset release -> one bin_valid pulse with bin_out=0100 (4), dir=1, step_err=0; no further pulses while the input is held.
- Count up: gray_in 0000 -> 0001 -> 0011 -> 0010, each held 5 cycles -> bin_out 0, 1, 2, 3 with dir=1; each bin_valid comes 3 edges after its change and lasts one cycle.
- Wrap both ways:
  - From 0000 drive 1000 -> bin_out=15, dir=0.
  - Then drive 0000 -> bin_out=0, dir=1.
- Multi-bit error: 0001 -> 0010 (1 -> 3) -> bin_out=3, bin_valid=1, step_err=1, dir unchanged.
  - Then 0010 -> 0110 -> bin_out=4, dir=1, step_err still 1.
  - Pulse err_clr -> step_err=0 next cycle.
- Error/clear collision: assert err_clr in the same cycle a multi-bit step is detected -> step_err=1 afterwards.
- Reset mid-run: assert rst while bin_out=7 -> all outputs 0 and dir=1 immediately; after release, bin_valid is silent for 2 cycles, then a seed pulse reports the current input.
